// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART TX arbiter.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitBusy,
    StWaitDone
  } arb_state_e;

  localparam int unsigned DefBusyTimeout = 4;

  // Width of a requester index; never below one bit.
  function automatic int unsigned grant_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Combinational winner picker for the UART TX arbiter.
// UART_TX_ARB_FIXED_PRIO_EN: lowest index always wins (may starve higher indices);
// otherwise round-robin starting one past i_last and wrapping.
module uart_arb_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdW     = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IdW-1:0]     i_last,
  output logic               o_any,
  output logic [IdW-1:0]     o_idx
);

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = ^i_last;

  // Scan downwards so the lowest asserted index is written last.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_any = 1'b1;
        o_idx = IdW'(i);
      end
    end
  end
`else
  logic [31:0] w_cand;

  // Scan offsets from farthest to nearest so the nearest candidate after i_last wins.
  always_comb begin
    o_any  = 1'b0;
    o_idx  = '0;
    w_cand = '0;
    for (int unsigned off = NUM_REQ; off >= 1; off--) begin
      w_cand = (32'(i_last) + off) % NUM_REQ;
      if (i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = IdW'(w_cand);
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_TX serializer among NUM_REQ byte producers.
// Optional build macro: UART_TX_ARB_FIXED_PRIO_EN selects fixed priority in the picker.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = DefBusyTimeout
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]     i_req_data,
  input  logic [NUM_REQ-1:0]           i_req_par_en,
  input  logic [NUM_REQ-1:0]           i_req_par_typ,
  output logic [NUM_REQ-1:0]           o_req_ack,
  output logic [WIDTH-1:0]             o_tx_p_data,
  output logic                         o_tx_data_valid,
  output logic                         o_tx_par_en,
  output logic                         o_tx_par_typ,
  input  logic                         i_tx_busy,
  output logic [grant_w(NUM_REQ)-1:0]  o_grant_id,
  output logic                         o_active,
  output logic                         o_err
);

  localparam int unsigned IdW  = grant_w(NUM_REQ);
  localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);

  arb_state_e       r_state, w_state_next;
  logic [IdW-1:0]   r_grant_id, r_last_grant, w_pick_idx;
  logic             w_pick_any, w_grant, w_err_set;
  logic [WIDTH-1:0] r_tx_data;
  logic             r_par_en, r_par_typ, r_err;
  logic [CntW-1:0]  r_cnt, w_cnt_next;

  uart_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IdW     (IdW)
  ) u_pick (
    .i_req  (i_req_valid),
    .i_last (r_last_grant),
    .o_any  (w_pick_any),
    .o_idx  (w_pick_idx)
  );

  // Next-state, grant strobe and busy-timeout counter.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_grant      = 1'b0;
    w_err_set    = 1'b0;
    unique case (r_state)
      StIdle: begin
        // A busy line with no launch of ours is a stale/external frame: hold off.
        if (!i_tx_busy && w_pick_any) begin
          w_grant      = 1'b1;
          w_state_next = StLaunch;
        end
      end
      StLaunch: begin
        w_cnt_next   = '0;
        w_state_next = StWaitBusy;
      end
      StWaitBusy: begin
        if (i_tx_busy) begin
          w_state_next = StWaitDone;
        end else if (r_cnt == CntW'(BUSY_TIMEOUT - 1)) begin
          w_err_set    = 1'b1;
          w_state_next = StIdle;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StWaitDone: begin
        if (!i_tx_busy) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State, frame latches and sticky error; winner's config captured on the grant edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_grant_id   <= '0;
      r_last_grant <= IdW'(NUM_REQ - 1);
      r_tx_data    <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_err_set) r_err <= 1'b1;
      if (w_grant) begin
        r_grant_id   <= w_pick_idx;
        r_last_grant <= w_pick_idx;
        r_tx_data    <= i_req_data[w_pick_idx*WIDTH +: WIDTH];
        r_par_en     <= i_req_par_en[w_pick_idx];
        r_par_typ    <= i_req_par_typ[w_pick_idx];
      end
    end
  end

  // Launch strobes are decoded from state so they last exactly one cycle.
  always_comb begin
    o_tx_data_valid = (r_state == StLaunch);
    o_req_ack       = o_tx_data_valid ? (NUM_REQ'(1) << r_grant_id) : '0;
    o_active        = (r_state != StIdle);
  end

  assign o_tx_p_data  = r_tx_data;
  assign o_tx_par_en  = r_par_en;
  assign o_tx_par_typ = r_par_typ;
  assign o_grant_id   = r_grant_id;
  assign o_err        = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART_TX model.
module tb_uart_tx_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   valid, par_en, par_typ, ack;
  logic [N*W-1:0] data;
  logic [W-1:0]   tx_data;
  logic           tx_dv, tx_pen, tx_ptyp, tx_busy, active, err;
  logic [1:0]     gid;
  logic           stub;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ackbad = 0;
  int n_unstable = 0;

  // Behavioural UART_TX: Busy rises the edge after DATA_VALID, one bit per cycle.
  logic       m_busy = 1'b0;
  logic       m_line = 1'b1;
  logic [9:0] m_shift = '0;
  int         m_left = 0;
  logic       lat_en = 1'b0;
  logic       lat_typ = 1'b0;
  bit         cap[$];

  assign tx_busy = stub ? 1'b0 : m_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .WIDTH        (W),
    .NUM_REQ      (N),
    .BUSY_TIMEOUT (4)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (valid),
    .i_req_data      (data),
    .i_req_par_en    (par_en),
    .i_req_par_typ   (par_typ),
    .o_req_ack       (ack),
    .o_tx_p_data     (tx_data),
    .o_tx_data_valid (tx_dv),
    .o_tx_par_en     (tx_pen),
    .o_tx_par_typ    (tx_ptyp),
    .i_tx_busy       (tx_busy),
    .o_grant_id      (gid),
    .o_active        (active),
    .o_err           (err)
  );

  always @(posedge clk) begin
    if (tx_dv) begin
      m_busy  <= 1'b1;
      m_line  <= 1'b0;
      m_shift <= tx_pen ? {1'b1, (^tx_data) ^ tx_ptyp, tx_data} : {2'b11, tx_data};
      m_left  <= tx_pen ? 10 : 9;
      lat_en  <= tx_pen;
      lat_typ <= tx_ptyp;
    end else if (m_left > 0) begin
      m_line  <= m_shift[0];
      m_shift <= m_shift >> 1;
      m_left  <= m_left - 1;
    end else begin
      m_busy <= 1'b0;
      m_line <= 1'b1;
    end
  end

  // Line capture, parity-config stability and ACK/DATA_VALID consistency monitors.
  always @(posedge clk) begin
    if (!stub && m_busy) begin
      cap.push_back(m_line);
      if (!rst && (tx_pen != lat_en || tx_ptyp != lat_typ)) n_unstable <= n_unstable + 1;
    end
    if ($countones(ack) > 1 || ack != (tx_dv ? (N'(1) << gid) : N'(0))) n_ackbad <= n_ackbad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ack(output int idx);
    idx = -1;
    for (int t = 0; t < 300 && idx < 0; t++) begin
      tick();
      if (ack != '0) begin
        for (int i = 0; i < N; i++) if (ack[i]) idx = i;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      tick();
      if (!active && !tx_busy) ok = 1'b1;
    end
  endtask

  task automatic check_frame(input string tag, input int len, input logic [7:0] exp_d,
                             input logic exp_p);
    logic [7:0] d;
    chk({tag, "_len"}, cap.size(), len);
    if (cap.size() == len) begin
      for (int i = 0; i < 8; i++) d[i] = cap[1+i];
      chk({tag, "_start"}, cap[0], 0);
      chk({tag, "_data"}, d, exp_d);
      if (len == 11) chk({tag, "_par"}, cap[9], exp_p);
      chk({tag, "_stop"}, cap[len-1], 1);
    end
  endtask

  initial begin
    int idx;
    bit ok;
    int u0;
    stub    = 1'b0;
    rst     = 1'b1;
    valid   = '0;
    data    = '0;
    par_en  = '0;
    par_typ = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    chk("rst_ack", ack, 0);
    chk("rst_dv", tx_dv, 0);
    chk("rst_pdata", tx_data, 0);
    chk("rst_par", {tx_pen, tx_ptyp}, 0);
    chk("rst_gid", gid, 0);
    chk("rst_active", active, 0);
    chk("rst_err", err, 0);

    // Single request, even parity: 0xCB has five ones so the parity bit is 1.
    data[7:0] = 8'hCB;
    par_en[0] = 1'b1;
    valid     = 4'b0001;
    tick();
    chk("s1_ack", ack, 4'b0001);
    chk("s1_dv", tx_dv, 1);
    chk("s1_pdata", tx_data, 8'hCB);
    valid = '0;
    cap.delete();
    tick();
    chk("s1_dv_once", tx_dv, 0);
    chk("s1_ack_once", ack, 0);
    chk("s1_active", active, 1);
    wait_idle(ok);
    chk("s1_done", ok, 1);
    check_frame("s1", 11, 8'hCB, 1'b1);

    // Four simultaneous requests after reset: order 0,1,2,3, each with the line idle.
    do_reset();
    data   = {8'h44, 8'h33, 8'h22, 8'h11};
    par_en = '0;
    valid  = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(idx);
      chk("s2_order", idx, k);
      chk("s2_byte", tx_data, 8'h11 * (k + 1));
      chk("s2_busy_low", tx_busy, 0);
      if (idx >= 0) valid[idx] = 1'b0;
    end
    wait_idle(ok);

    // Requester 2 holds, requester 0 requests twice: 0,2,0,2.
    do_reset();
    valid = 4'b0101;
    wait_ack(idx);
    chk("s3_g0", idx, 0);
    valid[0] = 1'b0;
    wait_ack(idx);
    chk("s3_g1", idx, 2);
    valid[0] = 1'b1;
    wait_ack(idx);
    chk("s3_g2", idx, 0);
    valid[0] = 1'b0;
    wait_ack(idx);
    chk("s3_g3", idx, 2);
    valid = '0;
    wait_idle(ok);

    // Per-requester parity: 0x07 odd -> parity bit 0; requester 3 without parity.
    u0          = n_unstable;
    data[15:8]  = 8'h07;
    par_en[1]   = 1'b1;
    par_typ[1]  = 1'b1;
    valid       = 4'b0010;
    wait_ack(idx);
    chk("s4_g1", idx, 1);
    chk("s4_par1", {tx_pen, tx_ptyp}, 2'b11);
    valid = '0;
    cap.delete();
    wait_idle(ok);
    check_frame("s4odd", 11, 8'h07, 1'b0);
    data[31:24] = 8'hA5;
    par_en[3]   = 1'b0;
    par_typ[3]  = 1'b1;
    valid       = 4'b1000;
    wait_ack(idx);
    chk("s4_g3", idx, 3);
    chk("s4_par3", tx_pen, 0);
    valid = '0;
    cap.delete();
    wait_idle(ok);
    check_frame("s4nopar", 10, 8'hA5, 1'b0);
    chk("s4_stable", n_unstable - u0, 0);

    // Busy never rises: four WAIT_BUSY cycles, then ERR and next requester.
    stub = 1'b1;
    do_reset();
    valid = 4'b0011;
    wait_ack(idx);
    chk("s5_g0", idx, 0);
    valid[0] = 1'b0;
    repeat (4) tick();
    chk("s5_err_pre", {active, err}, 2'b10);
    tick();
    chk("s5_err_set", {active, err}, 2'b01);
    tick();
    chk("s5_next_ack", ack, 4'b0010);
    valid = '0;
    wait_idle(ok);
    chk("s5_err_sticky", err, 1);
    stub = 1'b0;
    do_reset();
    chk("s5_err_clr", err, 0);
    wait_idle(ok);

    // Reset during WAIT_DONE: outputs clear, requester 0 regains priority.
    data[23:16] = 8'h5C;
    par_en[2]   = 1'b1;
    par_typ[2]  = 1'b1;
    valid       = 4'b0100;
    wait_ack(idx);
    chk("s6_g2", idx, 2);
    valid = '0;
    repeat (3) tick();
    chk("s6_in_frame", {active, tx_busy}, 2'b11);
    valid = 4'b0011;
    do_reset();
    chk("s6_rst_out", {ack, tx_dv, tx_pen, tx_ptyp, active, err}, 0);
    chk("s6_rst_data", {tx_data, gid}, 0);
    wait_ack(idx);
    chk("s6_prio0", idx, 0);
    chk("s6_busy_low", tx_busy, 0);
    valid = '0;
    wait_idle(ok);

    chk("ack_onehot", n_ackbad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART_TX serializer between NUM_REQ byte producers. It grants one requester at a time and latches that requester's byte and parity configuration. It launches the frame with a one-cycle DATA_VALID, then tracks the transmitter's Busy flag until the frame has left the line. It sits between the system's register-file/FIFO read ports and the UART_TX instance.

## Interface
Parameters:
- WIDTH, 8, data width per frame (matches UART_TX WIDTH)
- NUM_REQ, 4, number of requesters (2..8)
- BUSY_TIMEOUT, 4, max cycles to wait for TX_BUSY rise after launch

Ports:
- CLK  in  1  system clock; everything on rising edge
- RST  in  1  synchronous, active-high reset
- REQ_VALID  in  NUM_REQ  per-requester frame request; held until matching REQ_ACK
- REQ_DATA  in  NUM_REQ*WIDTH  requester i byte at [i*WIDTH +: WIDTH]
- REQ_PAR_EN  in  NUM_REQ  per-requester parity enable
- REQ_PAR_TYP  in  NUM_REQ  per-requester parity type (0 even, 1 odd)
- REQ_ACK  out  NUM_REQ  one-cycle one-hot pulse: request accepted
- TX_P_DATA  out  WIDTH  to UART_TX P_DATA
- TX_DATA_VALID  out  1  to UART_TX DATA_VALID, one-cycle pulse
- TX_PAR_EN  out  1  to UART_TX PAR_EN, stable for whole frame
- TX_PAR_TYP  out  1  to UART_TX PAR_TYP, stable for whole frame
- TX_BUSY  in  1  from UART_TX Busy
- GRANT_ID  out  $clog2(NUM_REQ)  index of current/last granted requester
- ACTIVE  out  1  high whenever state is not IDLE
- ERR  out  1  sticky: TX_BUSY never rose within BUSY_TIMEOUT

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE: if TX_BUSY=0 and any REQ_VALID is set, pick the winner and go to LAUNCH.
  - Round-robin search starts at last_grant+1 and wraps modulo NUM_REQ.
  - At that edge, latch REQ_DATA/REQ_PAR_EN/REQ_PAR_TYP of the winner into the TX_* registers and GRANT_ID.
  - If TX_BUSY=1 (external/stale frame), no grant; stay in IDLE.
- LAUNCH: TX_DATA_VALID=1 and REQ_ACK[GRANT_ID]=1 for exactly this cycle. Next state is WAIT_BUSY and the timeout counter is cleared.
- WAIT_BUSY: on TX_BUSY=1, go to WAIT_DONE.
  - Otherwise increment the counter.
  - When counter==BUSY_TIMEOUT-1 without TX_BUSY, set ERR and go to IDLE.
- WAIT_DONE: on TX_BUSY=0, go to IDLE.
- last_grant updates to GRANT_ID when LAUNCH is entered, so a timed-out requester does not starve others.
- TX_P_DATA/TX_PAR_EN/TX_PAR_TYP hold the latched values from LAUNCH through WAIT_DONE and remain until the next grant.
- Requester lowering REQ_VALID before ACK: it is simply not granted; no error.
- Request changes after the grant edge do not affect the frame in flight.

## Timing
- Reset values (1 cycle RST high):
  - state=IDLE, all outputs 0, ERR=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority after reset.
- RST asserted mid-frame: returns to IDLE next edge; TX_DATA_VALID=0; no ACK issued. The UART_TX frame in progress is not aborted by this block.
- Grant latency: REQ_VALID seen in IDLE at edge k → LAUNCH (DATA_VALID, ACK) during cycle k+1.
- Back-to-back: a grant is possible on the cycle after WAIT_DONE sees TX_BUSY=0. The minimum gap between DATA_VALID pulses is frame length+3 cycles.
- Simultaneous requests: exactly one ACK per frame, never two in one cycle.

## Configuration
- UART_TX_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; last_grant unused. Requester 0 can starve others (documented).
- Undefined (default): round-robin as above.

## Structure
- Package uart_tx_arb_pkg:
  - state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE)
  - default BUSY_TIMEOUT constant
  - GRANT_ID width function
- Sub-module uart_arb_rr_pick: combinational one-hot/index picker from request vector and last_grant.
  - Contains the UART_TX_ARB_FIXED_PRIO_EN branch.
- Top holds the FSM, latches and timeout counter.

## Test plan
Each scenario instantiates the arbiter with a real UART_TX, NUM_REQ=4.
- Single request: REQ_VALID=0001, data 8'hCB, even parity → ACK[0] one cycle after request, DATA_VALID one cycle. The serial line carries 11 bits that decode to 0xCB, parity 1.
- All four request simultaneously after reset with data 8'h11/22/33/44 → grants in order 0,1,2,3. Each ACK happens only after the previous frame's Busy falls.
- Requester 2 holds REQ_VALID continuously while 0 requests once → order is 0,2,… and 2 is not granted twice while 0 waits.
- Per-requester parity:
  - req1 PAR_EN=1, PAR_TYP=1 → odd parity bit.
  - req3 PAR_EN=0 → 10-bit frame; TX_PAR_* stable throughout Busy.
- TX_BUSY tied 0 (stub) → after BUSY_TIMEOUT=4 cycles in WAIT_BUSY: ERR=1, state IDLE, next requester granted. ERR stays 1 until RST.
- RST pulse during WAIT_DONE → all outputs 0 next cycle, ACTIVE=0, requester 0 has priority again.
